// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead time between the high and low sides.
// Optional fault latch and ports are built only when PWM_DEADTIME_FAULT_EN is defined.
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                enable_ni,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic                pwm_hi_o,
  output logic                pwm_lo_o,
  output logic [2:0]          state_o
`ifdef PWM_DEADTIME_FAULT_EN
  ,
  input  logic                fault_i,
  input  logic                fault_clr_i,
  output logic                fault_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_ON   = 3'd1,
    DT_RISE = 3'd2,
    HI_ON   = 3'd3,
    DT_FALL = 3'd4,
    FAULT   = 3'd5
  } state_e;

  state_e              state_q, state_d, state_nxt;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [DT_WIDTH-1:0] dt_load;
  logic                hi_q, hi_d;
  logic                lo_q, lo_d;
`ifdef PWM_DEADTIME_FAULT_EN
  logic                fault_q, fault_d;
`endif

  // A requested dead time of 0 behaves as 1, so the count loaded is max(dt,1)-1.
  assign dt_load = (deadtime_i == {DT_WIDTH{1'b0}}) ? {DT_WIDTH{1'b0}} : (deadtime_i - DT_WIDTH'(1));

  // Normal switching sequence, ignoring enable and fault overrides.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pwm_i) begin
          state_nxt = DT_RISE;
        end else begin
          state_nxt = DT_FALL;
        end
        cnt_nxt = dt_load;
      end
      LO_ON: begin
        if (pwm_i) begin
          state_nxt = DT_RISE;
          cnt_nxt   = dt_load;
        end else begin
          state_nxt = LO_ON;
        end
      end
      DT_RISE: begin
        if (!pwm_i) begin
          state_nxt = LO_ON;
        end else if (cnt_q == {DT_WIDTH{1'b0}}) begin
          state_nxt = HI_ON;
        end else begin
          cnt_nxt = cnt_q - DT_WIDTH'(1);
        end
      end
      HI_ON: begin
        if (!pwm_i) begin
          state_nxt = DT_FALL;
          cnt_nxt   = dt_load;
        end else begin
          state_nxt = HI_ON;
        end
      end
      DT_FALL: begin
        if (pwm_i) begin
          state_nxt = HI_ON;
        end else if (cnt_q == {DT_WIDTH{1'b0}}) begin
          state_nxt = LO_ON;
        end else begin
          cnt_nxt = cnt_q - DT_WIDTH'(1);
        end
      end
`ifdef PWM_DEADTIME_FAULT_EN
      FAULT: begin
        if (fault_clr_i && !fault_i) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FAULT;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {DT_WIDTH{1'b0}};
      end
    endcase
  end

  // Overrides: fault beats disable, disable beats normal switching; outputs decoded from next state.
  always_comb begin
    state_d = state_nxt;
    cnt_d   = cnt_nxt;
`ifdef PWM_DEADTIME_FAULT_EN
    if (fault_i) begin
      state_d = FAULT;
      cnt_d   = {DT_WIDTH{1'b0}};
    end else if (enable_ni && (state_q != FAULT)) begin
      state_d = IDLE;
      cnt_d   = {DT_WIDTH{1'b0}};
    end else begin
      state_d = state_nxt;
      cnt_d   = cnt_nxt;
    end
    fault_d = (state_d == FAULT);
`else
    if (enable_ni) begin
      state_d = IDLE;
      cnt_d   = {DT_WIDTH{1'b0}};
    end else begin
      state_d = state_nxt;
      cnt_d   = cnt_nxt;
    end
`endif
    hi_d = (state_d == HI_ON);
    lo_d = (state_d == LO_ON);
  end

  // State, counter and gate-drive registers share one edge so outputs never lag the state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= {DT_WIDTH{1'b0}};
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign pwm_hi_o = hi_q;
  assign pwm_lo_o = lo_q;
  assign state_o  = state_q;
`ifdef PWM_DEADTIME_FAULT_EN
  assign fault_o  = fault_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime; fault scenarios are included when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       enable_ni;
  logic       pwm_i;
  logic [7:0] deadtime_i;
  logic       pwm_hi_o;
  logic       pwm_lo_o;
  logic [2:0] state_o;
`ifdef PWM_DEADTIME_FAULT_EN
  logic       fault_i;
  logic       fault_clr_i;
  logic       fault_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .enable_ni  (enable_ni),
    .pwm_i      (pwm_i),
    .deadtime_i (deadtime_i),
    .pwm_hi_o   (pwm_hi_o),
    .pwm_lo_o   (pwm_lo_o),
    .state_o    (state_o)
`ifdef PWM_DEADTIME_FAULT_EN
    ,
    .fault_i    (fault_i),
    .fault_clr_i(fault_clr_i),
    .fault_o    (fault_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected state, high and low outputs after one clock edge; also checks no overlap.
  task automatic step(input string tag, input logic [2:0] st, input logic hi, input logic lo);
    @(posedge clk_i);
    #1;
    check({tag, ".state"}, {29'd0, state_o}, {29'd0, st});
    check({tag, ".hi"}, {31'd0, pwm_hi_o}, {31'd0, hi});
    check({tag, ".lo"}, {31'd0, pwm_lo_o}, {31'd0, lo});
    check({tag, ".overlap"}, {31'd0, pwm_hi_o & pwm_lo_o}, 32'd0);
  endtask

  initial begin
    reset_ni   = 1'b0;
    enable_ni  = 1'b1;
    pwm_i      = 1'b0;
    deadtime_i = 8'd4;
`ifdef PWM_DEADTIME_FAULT_EN
    fault_i     = 1'b0;
    fault_clr_i = 1'b0;
`endif
    #1;
    check("rst.state", {29'd0, state_o}, 32'd0);
    check("rst.hi", {31'd0, pwm_hi_o}, 32'd0);
    check("rst.lo", {31'd0, pwm_lo_o}, 32'd0);
    // Reset held across an edge with enable low must still hold IDLE.
    enable_ni = 1'b0;
    step("rst_hold", 3'd0, 1'b0, 1'b0);
    reset_ni  = 1'b1;
    enable_ni = 1'b1;
    step("idle_disabled", 3'd0, 1'b0, 1'b0);

    // Release from IDLE with pwm low: DT_FALL, then low side four edges later.
    enable_ni = 1'b0;
    step("start_fall", 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("start_dt", 3'd4, 1'b0, 1'b0);
    step("start_lo", 3'd1, 1'b0, 1'b1);
    step("lo_hold", 3'd1, 1'b0, 1'b1);

    // Rising dead time of 4; a mid-interval change of deadtime_i must be ignored.
    pwm_i = 1'b1;
    step("rise_n", 3'd2, 1'b0, 1'b0);
    deadtime_i = 8'd1;
    for (int i = 0; i < 3; i++) step("rise_dt", 3'd2, 1'b0, 1'b0);
    step("rise_hi", 3'd3, 1'b1, 1'b0);
    deadtime_i = 8'd4;

    // Falling dead time of 4.
    pwm_i = 1'b0;
    step("fall_n", 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("fall_dt", 3'd4, 1'b0, 1'b0);
    step("fall_lo", 3'd1, 1'b0, 1'b1);

    // Two-cycle pulse is swallowed and the low side comes straight back.
    pwm_i = 1'b1;
    step("swal_1", 3'd2, 1'b0, 1'b0);
    step("swal_2", 3'd2, 1'b0, 1'b0);
    pwm_i = 1'b0;
    step("swal_back", 3'd1, 1'b0, 1'b1);

    // Zero dead time behaves as one both-off cycle per transition.
    deadtime_i = 8'd0;
    pwm_i = 1'b1;
    step("dt0_rise", 3'd2, 1'b0, 1'b0);
    step("dt0_hi", 3'd3, 1'b1, 1'b0);
    pwm_i = 1'b0;
    step("dt0_fall", 3'd4, 1'b0, 1'b0);
    step("dt0_lo", 3'd1, 1'b0, 1'b1);
    pwm_i = 1'b1;
    step("dt0_rise2", 3'd2, 1'b0, 1'b0);
    step("dt0_hi2", 3'd3, 1'b1, 1'b0);

    // Disable from HI_ON drops both outputs at the next edge.
    enable_ni = 1'b1;
    step("dis", 3'd0, 1'b0, 1'b0);
    step("dis_hold", 3'd0, 1'b0, 1'b0);

    // Re-enable with pwm high and dead time 2, then abort a falling interval.
    enable_ni  = 1'b0;
    deadtime_i = 8'd2;
    step("en_rise", 3'd2, 1'b0, 1'b0);
    step("en_dt", 3'd2, 1'b0, 1'b0);
    step("en_hi", 3'd3, 1'b1, 1'b0);
    pwm_i = 1'b0;
    step("abort_fall", 3'd4, 1'b0, 1'b0);
    pwm_i = 1'b1;
    step("abort_back", 3'd3, 1'b1, 1'b0);
    pwm_i = 1'b0;
    step("fall2", 3'd4, 1'b0, 1'b0);
    step("fall2_dt", 3'd4, 1'b0, 1'b0);
    step("fall2_lo", 3'd1, 1'b0, 1'b1);

    // Asynchronous reset mid DT_RISE clears everything without a clock edge.
    pwm_i = 1'b1;
    step("pre_rst_rise", 3'd2, 1'b0, 1'b0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_rst.state", {29'd0, state_o}, 32'd0);
    check("async_rst.hi", {31'd0, pwm_hi_o}, 32'd0);
    check("async_rst.lo", {31'd0, pwm_lo_o}, 32'd0);
    step("async_rst_edge", 3'd0, 1'b0, 1'b0);
    reset_ni = 1'b1;

`ifdef PWM_DEADTIME_FAULT_EN
    deadtime_i = 8'd0;
    step("f_rise", 3'd2, 1'b0, 1'b0);
    step("f_hi", 3'd3, 1'b1, 1'b0);
    fault_i = 1'b1;
    step("f_trip", 3'd5, 1'b0, 1'b0);
    check("f_trip.fault_o", {31'd0, fault_o}, 32'd1);
    fault_i = 1'b0;
    enable_ni = 1'b1;
    step("f_dis_hold", 3'd5, 1'b0, 1'b0);
    enable_ni = 1'b0;
    fault_i = 1'b1;
    fault_clr_i = 1'b1;
    step("f_clr_ignored", 3'd5, 1'b0, 1'b0);
    check("f_clr_ignored.fault_o", {31'd0, fault_o}, 32'd1);
    fault_i = 1'b0;
    step("f_clr", 3'd0, 1'b0, 1'b0);
    check("f_clr.fault_o", {31'd0, fault_o}, 32'd0);
    fault_clr_i = 1'b0;
    step("f_resume", 3'd2, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 The block SHALL have parameter DT_WIDTH, default 8, giving the width of the dead-time count in clk_i cycles.
REQ-002 The block SHALL have the following ports:
- clk_i  input  1  clock
- reset_ni  input  1  reset, asynchronous, active-low
- enable_ni  input  1  active-low enable
- pwm_i  input  1  PWM from the upstream modulator, synchronous to clk_i
- deadtime_i  input  DT_WIDTH  dead-time length in cycles
- pwm_hi_o  output  1  high-side gate drive
- pwm_lo_o  output  1  low-side gate drive
- state_o  output  3  current FSM state code
REQ-003 Ports fault_i (input, 1), fault_clr_i (input, 1) and fault_o (output, 1) SHALL exist only when PWM_DEADTIME_FAULT_EN is defined.

Function
REQ-004 The FSM SHALL have these states and state_o codes: IDLE=0, LO_ON=1, DT_RISE=2, HI_ON=3, DT_FALL=4, FAULT=5.
REQ-005 pwm_hi_o and pwm_lo_o SHALL be registered, update on the same edge as the state register, and follow the state: pwm_hi_o=1 only in HI_ON, pwm_lo_o=1 only in LO_ON, both 0 in all other states.
REQ-006 pwm_hi_o and pwm_lo_o SHALL never be 1 in the same cycle.
REQ-007 The effective dead time SHALL be Deff = max(deadtime_i, 1); a deadtime_i of 0 SHALL be treated as 1.
REQ-008 On entry to DT_RISE or DT_FALL, the down-counter SHALL load Deff-1 from deadtime_i; later changes to deadtime_i during that interval SHALL be ignored.
REQ-009 In LO_ON with pwm_i=1, the next state SHALL be DT_RISE; in HI_ON with pwm_i=0, the next state SHALL be DT_FALL.
REQ-010 In DT_RISE, the FSM SHALL move to HI_ON when count==0 and pwm_i=1, and return to LO_ON at once if pwm_i=0, aborting the count.
REQ-011 In DT_FALL, the FSM SHALL move to LO_ON when count==0 and pwm_i=0, and return to HI_ON at once if pwm_i=1, aborting the count.
REQ-012 Latency: if pwm_i rises before edge N, pwm_lo_o SHALL fall at edge N and pwm_hi_o SHALL rise at edge N+Deff; the falling direction SHALL be symmetric.
REQ-013 A pwm_i pulse shorter than Deff cycles SHALL be swallowed: the opposite output never asserts and the previous output is restored.
REQ-014 With enable_ni=1, the next state SHALL be IDLE from any non-FAULT state, with both outputs 0 at that edge.
REQ-015 In IDLE with enable_ni=0, the next state SHALL be DT_RISE if pwm_i=1, else DT_FALL, so the first active output follows a full dead time.
REQ-016 The counter SHALL decrement by 1 per cycle only in DT states, SHALL saturate at 0 and SHALL never wrap.

Reset
REQ-017 Asserting reset_ni low SHALL immediately force state IDLE, count 0, pwm_hi_o=0, pwm_lo_o=0, state_o=0 and, if present, fault_o=0.
REQ-018 Reset asserted in any state, including mid dead-time, SHALL override all other inputs.
REQ-019 After reset release, the first transition out of IDLE SHALL occur no earlier than the first clk_i edge with enable_ni=0.

Configuration
REQ-020 With PWM_DEADTIME_FAULT_EN defined, fault_i=1 at an edge SHALL force FAULT from any state, both outputs 0 and fault_o=1 at that edge, with priority over enable_ni.
REQ-021 With PWM_DEADTIME_FAULT_EN defined, FAULT SHALL be left for IDLE only at an edge where fault_clr_i=1 and fault_i=0; fault_clr_i while fault_i=1 SHALL be ignored.
REQ-022 Without PWM_DEADTIME_FAULT_EN, the fault ports and logic SHALL be absent and code 5 SHALL be unreachable.

Verification
REQ-023 Soft reset release test: deadtime_i=4, enable_ni=0, pwm_i=0 -> state goes DT_FALL, then pwm_lo_o=1 four edges later.
REQ-024 Rising-edge dead-time test: deadtime_i=4, pwm_i rises at edge N while in LO_ON -> pwm_lo_o=0 at N, pwm_hi_o=1 at N+4, both 0 in between.
REQ-025 Swallowed-pulse test: deadtime_i=4, 2-cycle pwm_i pulse from LO_ON -> pwm_hi_o stays 0 and pwm_lo_o returns to 1 at the edge after pwm_i falls.
REQ-026 Zero dead-time test: deadtime_i=0 with pwm_i toggling -> exactly 1 both-off cycle per transition and no overlap.
REQ-027 Disable test: enable_ni=1 in HI_ON -> next edge both outputs 0 and state_o=0.
REQ-028 Fault test (macro defined): fault_i pulse in HI_ON -> outputs 0 and fault_o=1 at that edge; fault_clr_i with fault_i=0 -> IDLE; asynchronous reset mid DT_RISE -> all outputs 0 immediately.
